// File: rtl/csr_regfile_pkg.sv
// Shared parameters, CSR address map and trap payload type for the machine-mode CSR file.
package csr_regfile_pkg;

  localparam int unsigned XLEN                  = 64;
  localparam int unsigned EXCEPTION_CAUSE_WIDTH = 6;
  localparam int unsigned CSR_ADDR_W            = 12;
  localparam int unsigned RETIRE_W              = 2;
  localparam int unsigned MCAUSE_PAD_W          = XLEN - 1 - EXCEPTION_CAUSE_WIDTH;

  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MISA     = 12'h301;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIE      = 12'h304;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL    = 12'h343;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIP      = 12'h344;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET = 12'hB02;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE    = 12'hC00;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRET  = 12'hC02;
  localparam logic [CSR_ADDR_W-1:0] CSR_MHARTID  = 12'hF14;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LSB  = 11;
  localparam int unsigned MIP_MSIP_BIT     = 3;
  localparam int unsigned MIP_MTIP_BIT     = 7;
  localparam int unsigned MIP_MEIP_BIT     = 11;

  // MXL=2 (RV64) with the A, I and M extension bits set
  localparam logic [XLEN-1:0] MISA_VALUE  = 64'h8000_0000_0000_1101;
  localparam logic [XLEN-1:0] MIE_WR_MASK = XLEN'(64'h888);
  localparam logic [XLEN-1:0] MCAUSE_WR_MASK =
    {1'b1, {MCAUSE_PAD_W{1'b0}}, {EXCEPTION_CAUSE_WIDTH{1'b1}}};
  localparam logic [XLEN-1:0] EPC_MASK = ~XLEN'(1);

  typedef struct packed {
    logic                             is_intr;
    logic [EXCEPTION_CAUSE_WIDTH-1:0] cause;
    logic [XLEN-1:0]                  pc;
    logic [XLEN-1:0]                  tval;
  } trap_req_t;

  // Reserved mtvec modes (10/11) collapse to direct mode
  function automatic logic [XLEN-1:0] mtvec_legalize(input logic [XLEN-1:0] v);
    return v[1] ? {v[XLEN-1:2], 2'b00} : v;
  endfunction

endpackage

// File: rtl/csr_regfile_counter.sv
// Free-running counter with a load override that suppresses the increment in the load cycle.
module csr_counter
  import csr_regfile_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN,
  parameter int unsigned INC_W = RETIRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [INC_W-1:0] inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else begin
      count <= count + WIDTH'(inc);
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: combinational read port, one write port, trap/mret sequencing and counters.
module csr_regfile
  import csr_regfile_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CSR_ADDR_W-1:0]            csr_raddr_i,
  output logic [XLEN-1:0]                  csr_rdata_o,
  output logic                             csr_readable_o,
  output logic                             csr_writable_o,
  input  logic [CSR_ADDR_W-1:0]            csr_waddr_i,
  input  logic                             do_csr_write_i,
  input  logic [XLEN-1:0]                  csr_wrdata_i,
  input  logic                             trap_valid_i,
  input  logic                             trap_is_intr_i,
  input  logic [EXCEPTION_CAUSE_WIDTH-1:0] trap_cause_i,
  input  logic [XLEN-1:0]                  trap_pc_i,
  input  logic [XLEN-1:0]                  trap_tval_i,
  input  logic                             mret_valid_i,
  input  logic [RETIRE_W-1:0]              retire_cnt_i,
  input  logic                             msip_i,
  input  logic                             mtip_i,
  input  logic                             meip_i,
  output logic [XLEN-1:0]                  trap_target_o,
  output logic [XLEN-1:0]                  mepc_o,
  output logic                             irq_pending_o
);

  logic            mstatus_mie, mstatus_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] mcycle, minstret;
  logic [XLEN-1:0] mstatus_c, mip_c, mtvec_base_c;
  trap_req_t       trap;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
  logic wr_mcycle, wr_minstret;

  assign trap = '{is_intr: trap_is_intr_i, cause: trap_cause_i,
                  pc: trap_pc_i, tval: trap_tval_i};

  assign wr_mstatus  = do_csr_write_i && (csr_waddr_i == CSR_MSTATUS);
  assign wr_mie      = do_csr_write_i && (csr_waddr_i == CSR_MIE);
  assign wr_mtvec    = do_csr_write_i && (csr_waddr_i == CSR_MTVEC);
  assign wr_mscratch = do_csr_write_i && (csr_waddr_i == CSR_MSCRATCH);
  assign wr_mepc     = do_csr_write_i && (csr_waddr_i == CSR_MEPC);
  assign wr_mcause   = do_csr_write_i && (csr_waddr_i == CSR_MCAUSE);
  assign wr_mtval    = do_csr_write_i && (csr_waddr_i == CSR_MTVAL);
  assign wr_mcycle   = do_csr_write_i && (csr_waddr_i == CSR_MCYCLE);
  assign wr_minstret = do_csr_write_i && (csr_waddr_i == CSR_MINSTRET);

  // Architectural views of mstatus (MPP hardwired to M) and live interrupt lines
  always_comb begin
    mstatus_c = '0;
    mstatus_c[MSTATUS_MIE_BIT]                     = mstatus_mie;
    mstatus_c[MSTATUS_MPIE_BIT]                    = mstatus_mpie;
    mstatus_c[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB]   = 2'b11;
    mip_c = '0;
    mip_c[MIP_MSIP_BIT] = msip_i;
    mip_c[MIP_MTIP_BIT] = mtip_i;
    mip_c[MIP_MEIP_BIT] = meip_i;
  end

  always_comb begin
    csr_rdata_o    = '0;
    csr_readable_o = 1'b1;
    case (csr_raddr_i)
      CSR_MSTATUS:              csr_rdata_o = mstatus_c;
      CSR_MISA:                 csr_rdata_o = MISA_VALUE;
      CSR_MIE:                  csr_rdata_o = mie_q;
      CSR_MTVEC:                csr_rdata_o = mtvec_q;
      CSR_MSCRATCH:             csr_rdata_o = mscratch_q;
      CSR_MEPC:                 csr_rdata_o = mepc_q;
      CSR_MCAUSE:               csr_rdata_o = mcause_q;
      CSR_MTVAL:                csr_rdata_o = mtval_q;
      CSR_MIP:                  csr_rdata_o = mip_c;
      CSR_MCYCLE, CSR_CYCLE:    csr_rdata_o = mcycle;
      CSR_MINSTRET, CSR_INSTRET: csr_rdata_o = minstret;
      CSR_MHARTID:              csr_rdata_o = '0;
      default:                  csr_readable_o = 1'b0;
    endcase
  end

  assign csr_writable_o = csr_readable_o && (csr_raddr_i[11:10] != 2'b11);

  // Vectored mode only applies to interrupts
  assign mtvec_base_c = {mtvec_q[XLEN-1:2], 2'b00};
  always_comb begin
    trap_target_o = mtvec_base_c;
    if ((mtvec_q[1:0] == 2'b01) && trap_is_intr_i) begin
      trap_target_o = mtvec_base_c + (XLEN'(trap_cause_i) << 2);
    end
  end

  assign irq_pending_o = mstatus_mie && |(mip_c & mie_q);
  assign mepc_o        = mepc_q;

  // Trap-owned state: trap beats mret beats a software write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else if (trap_valid_i) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
      mepc_q       <= trap.pc & EPC_MASK;
      mcause_q     <= {trap.is_intr, {MCAUSE_PAD_W{1'b0}}, trap.cause};
      mtval_q      <= trap.tval;
    end else begin
      if (mret_valid_i) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wr_mstatus) begin
        mstatus_mie  <= csr_wrdata_i[MSTATUS_MIE_BIT];
        mstatus_mpie <= csr_wrdata_i[MSTATUS_MPIE_BIT];
      end
      if (wr_mepc)   mepc_q   <= csr_wrdata_i & EPC_MASK;
      if (wr_mcause) mcause_q <= csr_wrdata_i & MCAUSE_WR_MASK;
      if (wr_mtval)  mtval_q  <= csr_wrdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
    end else begin
      if (wr_mie)      mie_q      <= csr_wrdata_i & MIE_WR_MASK;
      if (wr_mtvec)    mtvec_q    <= mtvec_legalize(csr_wrdata_i);
      if (wr_mscratch) mscratch_q <= csr_wrdata_i;
    end
  end

  csr_counter #(.WIDTH(XLEN), .INC_W(RETIRE_W)) u_mcycle (
    .clk      (clk),
    .rst_n    (rst),
    .load     (wr_mcycle),
    .load_val (csr_wrdata_i),
    .inc      (RETIRE_W'(1)),
    .count    (mcycle)
  );

  csr_counter #(.WIDTH(XLEN), .INC_W(RETIRE_W)) u_minstret (
    .clk      (clk),
    .rst_n    (rst),
    .load     (wr_minstret),
    .load_val (csr_wrdata_i),
    .inc      (retire_cnt_i),
    .count    (minstret)
  );

endmodule
